// File: rtl/intr_arbiter.sv
// intr_arbiter: synchronises, latches and masks seven interrupt requests and presents
// the highest eligible one as a stable 3-bit code, tracking in-service levels for nesting.
module intr_arbiter #(
  parameter logic [6:0] EDGE_MASK   = 7'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] irq_i,
  input  logic       mask_we_i,
  input  logic [6:0] mask_data_i,
  output logic [6:0] mask_o,
  input  logic       exc_i,
  input  logic       eoi_i,
  output logic [2:0] interrupts_o,
  output logic [6:0] pending_o,
  output logic [6:0] isr_o
);
  typedef enum logic [1:0] {IDLE, PRESENT, ACKED} state_t;
  state_t     r_state, w_state_nxt;
  logic [6:0] r_sync [SYNC_STAGES];
  logic [6:0] r_s_prev, r_pend, r_mask, r_isr;
  logic [6:0] w_s, w_elig, w_cur_oh, w_ack_oh, w_eoi_oh;
  logic [2:0] r_cur, r_int, w_top, w_win, w_cur_nxt, w_int_nxt;
  logic       w_win_v;
  assign w_s = r_sync[SYNC_STAGES-1];
  always_ff @(posedge clk_i)
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= irq_i;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  // only levels strictly above the highest in-service bit may nest
  always_comb begin
    w_top = '0;
    for (int i = 0; i < 7; i++) if (r_isr[i]) w_top = 3'(i);
    w_elig = '0;
    for (int i = 0; i < 7; i++) w_elig[i] = r_pend[i] & ~r_mask[i] & (r_isr == '0 || 3'(i) > w_top);
    w_win = '0;
    for (int i = 0; i < 7; i++) if (w_elig[i]) w_win = 3'(i);
  end
  assign w_win_v  = |w_elig;
  assign w_cur_oh = (r_cur != 3'd0) ? 7'd1 << (r_cur - 3'd1) : '0;
  assign w_ack_oh = exc_i ? w_cur_oh : '0;
  assign w_eoi_oh = (eoi_i && r_isr != '0) ? 7'd1 << w_top : '0;
  always_comb begin
    w_state_nxt = r_state;
    w_int_nxt   = '0;
    w_cur_nxt   = r_cur;
    case (r_state)
      IDLE:
        if (!exc_i && w_win_v) begin
          w_state_nxt = PRESENT;
          w_cur_nxt   = w_win + 3'd1;
          w_int_nxt   = w_win + 3'd1;
        end
      PRESENT:
        if (exc_i) w_state_nxt = ACKED;
        else if ((w_elig & w_cur_oh) == '0) w_state_nxt = IDLE;
        else w_int_nxt = r_cur;
      default: w_state_nxt = IDLE;
    endcase
  end
  // an edge arriving on the ack edge must survive, so set is OR'd after the clear
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_state  <= IDLE;
      r_int    <= '0;
      r_cur    <= '0;
      r_s_prev <= '0;
      r_pend   <= '0;
      r_isr    <= '0;
      r_mask   <= 7'h7f;
    end else begin
      r_state  <= w_state_nxt;
      r_int    <= w_int_nxt;
      r_cur    <= w_cur_nxt;
      r_s_prev <= w_s;
      r_pend   <= (EDGE_MASK & ((w_s & ~r_s_prev) | (r_pend & ~w_ack_oh))) | (~EDGE_MASK & w_s);
      r_isr    <= (r_isr & ~w_eoi_oh) | w_ack_oh;
      if (mask_we_i) r_mask <= mask_data_i;
    end
  assign interrupts_o = r_int;
  assign pending_o    = r_pend;
  assign isr_o        = r_isr;
  assign mask_o       = r_mask;
endmodule

// File: tb/tb_intr_arbiter.sv
// tb_intr_arbiter: scheduled-expectation scoreboard for intr_arbiter (source 3 edge-triggered).
module tb_intr_arbiter;
  logic       clk = 0, rst_i = 1, mask_we_i = 0, exc_i = 0, eoi_i = 0;
  logic [6:0] irq_i = '0, mask_data_i = '0, mask_o, pending_o, isr_o;
  logic [2:0] interrupts_o;
  int         cyc = 0, n_chk = 0, n_err = 0;
  typedef struct {int cyc; string tag; int sel; logic [6:0] val;} sb_t;
  sb_t sb[$];
  intr_arbiter #(.EDGE_MASK(7'h08), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .irq_i(irq_i), .mask_we_i(mask_we_i),
    .mask_data_i(mask_data_i), .mask_o(mask_o), .exc_i(exc_i), .eoi_i(eoi_i),
    .interrupts_o(interrupts_o), .pending_o(pending_o), .isr_o(isr_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask
  function automatic logic [6:0] obs_of(input int sel);
    return sel == 0 ? {4'b0, interrupts_o} : sel == 1 ? isr_o : sel == 2 ? pending_o : mask_o;
  endfunction
  always @(negedge clk)
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].cyc == cyc) begin
        chk(sb[i].tag, obs_of(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
  task automatic push_exp(input int d, input string tag, input int sel, input logic [6:0] v);
    sb.push_back('{cyc + d, tag, sel, v});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_eoi();
    eoi_i = 1;
    tick();
    eoi_i = 0;
  endtask
  initial begin
    tick();
    push_exp(0, "rst_int", 0, 0);
    push_exp(0, "rst_mask", 3, 7'h7f);
    push_exp(0, "rst_pend", 2, 0);
    push_exp(0, "rst_isr", 1, 0);
    rst_i = 0;
    tick();
    mask_we_i = 1; mask_data_i = 7'h00;
    push_exp(1, "mask_clr", 3, 0);
    tick();
    mask_we_i = 0;
    irq_i[2] = 1;
    push_exp(3, "lat_early", 0, 0);
    push_exp(4, "lat_code3", 0, 3);
    repeat (4) tick();
    exc_i = 1;
    push_exp(1, "ack_int0", 0, 0);
    push_exp(1, "ack_isr", 1, 7'h04);
    tick();
    exc_i = 0;
    repeat (3) tick();
    push_exp(0, "no_repres", 0, 0);
    push_exp(0, "isr_held", 1, 7'h04);
    eoi_i = 1;
    push_exp(1, "eoi_isr", 1, 0);
    push_exp(2, "re_code3", 0, 3);
    tick();
    eoi_i = 0;
    tick();
    irq_i[2] = 0;
    push_exp(3, "wd_hold", 0, 3);
    push_exp(4, "wd_zero", 0, 0);
    repeat (6) tick();
    irq_i = 7'h22;
    push_exp(4, "pri_code6", 0, 6);
    repeat (4) tick();
    exc_i = 1;
    push_exp(1, "pri_isr", 1, 7'h20);
    tick();
    exc_i = 0; irq_i[5] = 0;
    repeat (4) tick();
    push_exp(0, "pri_pend", 2, 7'h02);
    push_exp(0, "pri_wait", 0, 0);
    eoi_i = 1;
    push_exp(2, "pri_code2", 0, 2);
    tick();
    eoi_i = 0;
    tick();
    irq_i = '0;
    repeat (6) tick();
    irq_i = 7'h04;
    push_exp(4, "nest_c3", 0, 3);
    repeat (4) tick();
    exc_i = 1;
    push_exp(1, "nest_isr1", 1, 7'h04);
    tick();
    exc_i = 0; irq_i = 7'h44;
    push_exp(4, "nest_c7", 0, 7);
    repeat (4) tick();
    exc_i = 1;
    push_exp(1, "nest_isr2", 1, 7'h44);
    tick();
    exc_i = 0; irq_i = 7'h01;
    push_exp(3, "nest_pend", 2, 7'h01);
    push_exp(4, "nest_block", 0, 0);
    repeat (5) tick();
    eoi_i = 1;
    push_exp(1, "nest_eoi1", 1, 7'h04);
    tick();
    push_exp(1, "nest_eoi2", 1, 0);
    push_exp(2, "nest_c1", 0, 1);
    tick();
    eoi_i = 0;
    tick();
    exc_i = 1; irq_i = '0;
    push_exp(1, "nest_isr3", 1, 7'h01);
    tick();
    exc_i = 0;
    repeat (5) tick();
    pulse_eoi();
    repeat (3) tick();
    irq_i[3] = 1;
    push_exp(4, "edge_c4", 0, 4);
    tick();
    irq_i[3] = 0;
    repeat (5) tick();
    push_exp(0, "edge_pend", 2, 7'h08);
    push_exp(0, "edge_hold", 0, 4);
    exc_i = 1;
    push_exp(1, "edge_clr", 2, 0);
    push_exp(1, "edge_isr", 1, 7'h08);
    tick();
    exc_i = 0;
    tick();
    irq_i[3] = 1;
    tick();
    irq_i[3] = 0;
    tick();
    exc_i = 1;
    push_exp(1, "edge_setwin", 2, 7'h08);
    push_exp(1, "edge_isrkeep", 1, 7'h08);
    tick();
    exc_i = 0;
    tick();
    eoi_i = 1;
    push_exp(1, "edge_isr0", 1, 0);
    push_exp(2, "edge_rep", 0, 4);
    tick();
    eoi_i = 0;
    tick();
    exc_i = 1;
    tick();
    exc_i = 0;
    tick();
    pulse_eoi();
    repeat (3) tick();
    irq_i[4] = 1;
    push_exp(4, "wd_c5", 0, 5);
    repeat (4) tick();
    irq_i[4] = 0;
    push_exp(3, "wd_c5hold", 0, 5);
    push_exp(4, "wd_c5zero", 0, 0);
    repeat (4) tick();
    exc_i = 1;
    push_exp(1, "late_isr", 1, 7'h10);
    push_exp(1, "late_int", 0, 0);
    tick();
    exc_i = 0;
    pulse_eoi();
    repeat (3) tick();
    irq_i[4] = 1;
    push_exp(4, "msk_c5", 0, 5);
    repeat (4) tick();
    mask_we_i = 1; mask_data_i = 7'h10;
    push_exp(1, "msk_reg", 3, 7'h10);
    push_exp(1, "msk_c5hold", 0, 5);
    push_exp(2, "msk_wd", 0, 0);
    push_exp(2, "msk_pend", 2, 7'h10);
    tick();
    mask_we_i = 0;
    repeat (2) tick();
    mask_we_i = 1; mask_data_i = 7'h00;
    push_exp(2, "msk_rep", 0, 5);
    tick();
    mask_we_i = 0;
    tick();
    rst_i = 1;
    push_exp(1, "rst2_int", 0, 0);
    push_exp(1, "rst2_mask", 3, 7'h7f);
    push_exp(1, "rst2_pend", 2, 0);
    push_exp(1, "rst2_isr", 1, 0);
    tick();
    rst_i = 0; exc_i = 1;
    push_exp(1, "spur_isr", 1, 0);
    push_exp(1, "spur_int", 0, 0);
    push_exp(1, "spur_pend", 2, 0);
    tick();
    exc_i = 0; irq_i = '0;
    repeat (3) tick();
    chk("sb_empty", 7'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/intr_arbiter.md
Name: intr_arbiter

Overview:
Interrupt controller that produces the 3-bit `interrupts` code consumed by the execute stage. It synchronises and latches seven external requests and applies a software mask. It presents the highest-priority eligible request as a stable code and tracks in-service levels so only higher priorities can nest. Acknowledge comes from execute's `exc_o`; end-of-interrupt comes from the return-from-interrupt path.

Parameters:
EDGE_MASK, 7'h00, bit n=1: source n is rising-edge triggered; bit n=0: level triggered (active high)
SYNC_STAGES, 2, flops per source in the input synchroniser; legal range 1..3

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous reset, active high
irq_i  input  7  raw request lines; source n maps to code n+1 (7 = highest priority)
mask_we_i  input  1  write strobe for mask register
mask_data_i  input  7  new mask value, bit n=1 masks source n
mask_o  output  7  current mask register
exc_i  input  1  interrupt-taken pulse (execute `exc_o`), one cycle after execute sampled the code
eoi_i  input  1  end-of-interrupt pulse, retires the highest in-service level
interrupts_o  output  3  code to execute `interrupts`; 0 = none
pending_o  output  7  pending register (post-sync)
isr_o  output  7  in-service register

Behaviour:
- Reset values (synchronous, rst_i high at a clock edge):
  - mask_o=7'h7f, pending_o=0, isr_o=0, interrupts_o=0, cur_code=0, state=IDLE.
  - Synchroniser and edge-history flops reset to 0.
  - rst_i mid-presentation abandons it; an exc_i in the cycle after reset is ignored because cur_code=0.
- Sync: irq_i passes through SYNC_STAGES flops, giving s[n]. The edge detector compares s[n] with its previous value.
- Pending:
  - Edge source: set on the rising edge of s[n]; cleared only by an ack of that source. Set wins over clear in the same cycle.
  - Level source: pending[n] = s[n], registered.
- Mask: on mask_we_i, mask_o <= mask_data_i next edge. Masking does not clear pending.
- Eligibility: source n is eligible when pending[n] & ~mask[n] & (n > index of highest set isr bit, or isr==0). The winner is the highest eligible n.
- cur_code register: holds the last presented code (n+1). It persists until the next IDLE->PRESENT transition.
- Ack processing runs in every state. If exc_i=1 and cur_code!=0, with k=cur_code-1:
  - isr[k] <= 1.
  - If source k is edge-triggered, pending[k] <= 0.
  - If exc_i=1 and cur_code==0, nothing happens.
- EOI: eoi_i clears the highest set isr bit, evaluated on isr before any same-cycle ack set. With isr==0 it has no effect.
- FSM:
  - IDLE: interrupts_o=0. If exc_i=0 and an eligible winner exists: cur_code<=winner+1, interrupts_o<=winner+1, go to PRESENT. If exc_i=1, stay IDLE this cycle.
  - PRESENT: interrupts_o holds cur_code and never changes code while in PRESENT. A newly eligible higher priority waits.
    - If exc_i=1: go to ACKED, interrupts_o<=0.
    - Else if the presented source is no longer eligible (level drop, mask set, or EOI-induced change is irrelevant): go to IDLE, interrupts_o<=0 (withdraw).
  - ACKED: interrupts_o=0 for exactly one cycle, then IDLE.
- Timing guarantees:
  - Minimum request-to-code latency is SYNC_STAGES+2 cycles (sync, pending register, presentation register).
  - After any withdrawal or ack, at least one cycle of interrupts_o=0 occurs before a new code. A late exc_i for the old code therefore always targets cur_code correctly.
- Simultaneous events:
  - Ack and mask write in the same cycle: both take effect.
  - Ack and EOI in the same cycle: EOI clears the old top level first, then the ack sets isr[k].
  - Edge re-asserted during service: pending is set again. It is presented only after EOI lowers the isr level, or if it is higher than the current level.

Test Plan:
- Reset, then mask_we_i with 7'h00, irq_i[2] level held high: interrupts_o=3 exactly SYNC_STAGES+2 cycles after irq rise. Pulse exc_i: interrupts_o=0, isr_o=7'h04. No re-present while isr set; eoi_i clears isr_o=0, then code 3 returns.
- irq_i[1] and irq_i[5] rise the same cycle, both unmasked: code 6 presented first. After exc_i then eoi_i, code 2 is presented.
- Nesting: ack source 2 (isr=7'h04), raise irq_i[6]: code 7 presented and acked (isr=7'h44). Raise irq_i[0]: not presented. First eoi_i gives isr=7'h04; second gives 0; then code 1 presented.
- EDGE_MASK=7'h08, one-cycle pulse on irq_i[3]: pending_o[3]=1 persists and code 4 is presented. Ack clears pending_o[3]. A pulse arriving on the same edge as the ack leaves pending_o[3]=1.
- Withdraw: level irq_i[4] presented (code 5); drop irq_i[4] with no exc_i: interrupts_o=0 within SYNC_STAGES+2 cycles. exc_i arriving in the first zero cycle still sets isr[4]. Spurious exc_i after reset: no state change.
- Mask: present code 5, set mask bit 4 via mask_we_i: withdrawal to 0, pending_o[4] unchanged. Assert rst_i while in PRESENT: all outputs return to reset values next edge.
